regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port register file for the pipeline, with a per-register
//  scoreboard (busy bits) and same-cycle write-to-read bypass.
//  After reset it runs a self-clearing sweep, one entry per cycle.
//  Serves decode (operand and store-data reads) and writeback (NWR result ports).
// PARAMETERS
//  DATA_W   32                 register width in bits
//  REG_NUM  32                 number of registers
//  ADDR_W   $clog2(REG_NUM)    register address width
//  NRD      3                  read ports (operand 1, operand 2, store data)
//  NWR      2                  write ports (ALU and load writeback)
// PORTS
//  clk       in   1             clock; all state updates on the rising edge
//  rst       in   1             reset, asynchronous assert, active-low
//  clr_req   in   1             request a re-clear sweep; sampled only in READY
//  ready     out  1             1 = sweep done, file usable
//  re        in   NRD           per-port read enable
//  raddr     in   NRD*ADDR_W    read addresses; port k at [k*ADDR_W +: ADDR_W]
//  rdata     out  NRD*DATA_W    read data (combinational)
//  rbusy     out  NRD           addressed register has a pending producer
//  we        in   NWR           per-port write enable
//  waddr     in   NWR*ADDR_W    write addresses
//  wdata     in   NWR*DATA_W    write data
//  iss_valid in   1             an instruction with a destination is issuing
//  iss_addr  in   ADDR_W        destination register of that instruction
//  iss_err   out  1             1-cycle pulse: issue targeted an already-busy register
// BEHAVIOUR
//  Reset (rst=0), effective immediately:
//   - state=INIT, sweep cnt=0, all busy=0, ready=0, iss_err=0.
//   - rdata=0 and rbusy=0 while rst=0.
//   - Storage array is not reset directly; the sweep clears it.
//  FSM INIT:
//   - Each cycle writes 0 to entry cnt, then cnt++.
//   - When cnt==REG_NUM-1 that entry is written and the next state is READY.
//   - ready=1 on the first READY cycle, exactly REG_NUM cycles after rst release.
//   - In INIT, we, iss_valid and clr_req are ignored; rdata=0, rbusy=0.
//  FSM READY:
//   - clr_req=1 -> INIT next cycle with cnt=0, all busy=0, ready=0 next cycle.
//   - Writes are still committed in the clr_req cycle; the sweep overwrites them.
//  Rst asserted mid-sweep or mid-operation: the sweep restarts from cnt=0.
//  Write (READY only):
//   - we[j] -> rf[waddr[j]] <= wdata[j] at the clock edge.
//   - Two ports to the same address: the highest port index wins.
//   - Each write clears busy[waddr[j]].
//  Read (READY only), per port k, combinational, zero latency:
//   - re[k]=0 -> rdata[k]=0, rbusy[k]=0.
//   - Otherwise, if any we[j] targets raddr[k] this cycle, rdata[k]=wdata of the
//     highest such j (bypass) and rbusy[k]=0.
//   - Otherwise rdata[k]=rf[raddr[k]] and rbusy[k]=busy[raddr[k]].
//  Scoreboard:
//   - iss_valid sets busy[iss_addr] at the clock edge.
//   - Set beats a same-cycle clear on the same register (new producer wins).
//   - A same-cycle read of iss_addr still sees the pre-issue busy value.
//   - iss_err is registered and equals 1 for one cycle after an issue where
//     busy[iss_addr]=1 and no same-cycle write clears it. busy stays 1.
//  All address arithmetic is unsigned. Addresses >= REG_NUM (non-power-of-2
//  REG_NUM): writes and issues are dropped; reads return 0 with rbusy=0.
// TESTING
//  1. Release rst, REG_NUM=32 -> ready rises on cycle 32. Read all 32 -> 0.
//     Assert rst at cycle 10 -> ready=0 and the sweep restarts, ready at 32 after release.
//  2. Write r5=0xDEAD_BEEF via port 0, read r5 the same cycle on port 1
//     -> rdata=0xDEADBEEF (bypass). Next cycle without write -> still 0xDEADBEEF.
//  3. Same cycle we[0] r7=0x1111 and we[1] r7=0x2222 -> r7 reads 0x2222 afterwards.
//  4. Issue r3 -> rbusy for r3 =1 next cycle. Writeback r3 -> rbusy=0 in the same
//     cycle via bypass. Issue r3 and write r3 together -> busy stays 1.
//  5. Issue r4 twice with no writeback -> iss_err=1 for exactly one cycle, busy[4]=1.
//  6. In READY write r9=0x55, pulse clr_req -> ready low for 32 cycles, then r9 reads 0,
//     all rbusy=0. Writes and issues during the sweep have no effect.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard, same-cycle
// write-to-read bypass and a post-reset clearing sweep (one entry per cycle).
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = $clog2(REG_NUM),
    parameter int NRD     = 3,
    parameter int NWR     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_req,
    output logic                   ready,
    input  logic [NRD-1:0]         re,
    input  logic [NRD*ADDR_W-1:0]  raddr,
    output logic [NRD*DATA_W-1:0]  rdata,
    output logic [NRD-1:0]         rbusy,
    input  logic [NWR-1:0]         we,
    input  logic [NWR*ADDR_W-1:0]  waddr,
    input  logic [NWR*DATA_W-1:0]  wdata,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic                   iss_err
);

    localparam logic [0:0]        S_INIT  = 1'b0;
    localparam logic [0:0]        S_READY = 1'b1;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(REG_NUM - 1);
    localparam logic [ADDR_W:0]   LIMIT   = (ADDR_W + 1)'(REG_NUM);

    // Addresses beyond the populated range are dropped (writes/issues) or read as 0.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < LIMIT);
    endfunction

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic               iss_err_q, iss_err_d;
    logic [DATA_W-1:0]  rf_q [REG_NUM];
    logic [DATA_W-1:0]  rf_d [REG_NUM];

    // Next-state logic: sweep, writeback commits and scoreboard updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        iss_err_d = 1'b0;
        rf_d      = rf_q;
        case (state_q)
            S_INIT: begin
                rf_d[cnt_q] = '0;
                busy_d      = '0;
                if (cnt_q == LAST) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_READY: begin
                // Ascending port order makes the highest-index writer win.
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && addr_ok(waddr[j*ADDR_W +: ADDR_W])) begin
                        rf_d[waddr[j*ADDR_W +: ADDR_W]]   = wdata[j*DATA_W +: DATA_W];
                        busy_d[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
                    end else begin
                        busy_d = busy_d;
                    end
                end
                // busy_d already reflects same-cycle clears, so it flags a real double issue.
                if (iss_valid && addr_ok(iss_addr)) begin
                    iss_err_d        = busy_d[iss_addr];
                    busy_d[iss_addr] = 1'b1;
                end else begin
                    iss_err_d = 1'b0;
                end
                if (clr_req) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    busy_d  = '0;
                end else begin
                    state_d = S_READY;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                busy_d  = '0;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            busy_q    <= '0;
            iss_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            iss_err_q <= iss_err_d;
        end
    end

    // Storage array; cleared by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    // Combinational read ports with write bypass.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            if ((state_q == S_READY) && re[k] && addr_ok(raddr[k*ADDR_W +: ADDR_W])) begin
                rdata[k*DATA_W +: DATA_W] = rf_q[raddr[k*ADDR_W +: ADDR_W]];
                rbusy[k]                  = busy_q[raddr[k*ADDR_W +: ADDR_W]];
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W])) begin
                        rdata[k*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
                        rbusy[k]                  = 1'b0;
                    end else begin
                        rbusy[k] = rbusy[k];
                    end
                end
            end else begin
                rbusy[k] = 1'b0;
            end
        end
    end

    assign ready   = (state_q == S_READY);
    assign iss_err = iss_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep timing, bypass, write priority,
// scoreboard and issue-error behaviour, clear sweep.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr_req;
    logic            ready;
    logic [2:0]      re;
    logic [3*AW-1:0] raddr;
    logic [3*DW-1:0] rdata;
    logic [2:0]      rbusy;
    logic [1:0]      we;
    logic [2*AW-1:0] waddr;
    logic [2*DW-1:0] wdata;
    logic            iss_valid;
    logic [AW-1:0]   iss_addr;
    logic            iss_err;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_err(iss_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        re[k]             = 1'b1;
        raddr[k*AW +: AW] = a;
    endtask

    task automatic wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[j]             = 1'b1;
        waddr[j*AW +: AW] = a;
        wdata[j*DW +: DW] = d;
    endtask

    task automatic idle();
        re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_addr = '0; clr_req = 1'b0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 1; i < 32; i++) step();
        chk({tag, "_ready_c31"}, {31'd0, ready}, 32'd0);
        step();
        chk({tag, "_ready_c32"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rd(0, 5'd0); rd(1, 5'd1); rd(2, 5'd2);
        repeat (3) step();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rdata", rdata[31:0], 32'd0);
        chk("rst_rbusy", {29'd0, rbusy}, 32'd0);
        chk("rst_iss_err", {31'd0, iss_err}, 32'd0);

        // 1. Sweep after reset release, then every entry reads 0.
        rst = 1'b1;
        sweep_check("sweep1");
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a));
            #1;
            chk($sformatf("clear_r%0d", a), rdata[31:0], 32'd0);
        end
        idle();

        // Reset mid-sweep restarts the count.
        rst = 1'b0;
        #1;
        chk("rst_ready_drop", {31'd0, ready}, 32'd0);
        step();
        rst = 1'b1;
        repeat (10) step();
        rst = 1'b0;
        #1;
        chk("midsweep_ready", {31'd0, ready}, 32'd0);
        step();
        rst = 1'b1;
        sweep_check("sweep2");

        // 2. Bypass, then stored value.
        wr(0, 5'd5, 32'hDEAD_BEEF);
        rd(1, 5'd5);
        #1;
        chk("bypass_r5", rdata[63:32], 32'hDEAD_BEEF);
        step();
        we = '0;
        #1;
        chk("stored_r5", rdata[63:32], 32'hDEAD_BEEF);
        idle();

        // 3. Two writers, same address: port 1 wins.
        wr(0, 5'd7, 32'h1111);
        wr(1, 5'd7, 32'h2222);
        rd(2, 5'd7);
        #1;
        chk("bypass_prio_r7", rdata[95:64], 32'h2222);
        step();
        idle();
        rd(0, 5'd7);
        #1;
        chk("stored_prio_r7", rdata[31:0], 32'h2222);
        idle();

        // 4. Scoreboard on r3.
        rd(0, 5'd3);
        iss_valid = 1'b1; iss_addr = 5'd3;
        #1;
        chk("issue_pre_busy", {31'd0, rbusy[0]}, 32'd0);
        step();
        iss_valid = 1'b0;
        #1;
        chk("issue_busy_r3", {31'd0, rbusy[0]}, 32'd1);
        wr(1, 5'd3, 32'h33);
        #1;
        chk("wb_bypass_busy", {31'd0, rbusy[0]}, 32'd0);
        chk("wb_bypass_data", rdata[31:0], 32'h33);
        step();
        we = '0;
        #1;
        chk("wb_cleared_busy", {31'd0, rbusy[0]}, 32'd0);
        iss_valid = 1'b1; iss_addr = 5'd3;
        wr(0, 5'd3, 32'h44);
        step();
        iss_valid = 1'b0; we = '0;
        #1;
        chk("set_beats_clear", {31'd0, rbusy[0]}, 32'd1);
        chk("set_clear_data", rdata[31:0], 32'h44);
        chk("set_clear_no_err", {31'd0, iss_err}, 32'd0);
        // Re-issue while busy but with a same-cycle writeback: no error.
        iss_valid = 1'b1; iss_addr = 5'd3;
        wr(1, 5'd3, 32'h55);
        step();
        iss_valid = 1'b0; we = '0;
        #1;
        chk("reissue_wb_no_err", {31'd0, iss_err}, 32'd0);
        chk("reissue_wb_busy", {31'd0, rbusy[0]}, 32'd1);
        wr(0, 5'd3, 32'h66);
        step();
        idle();

        // 5. Double issue on r4.
        rd(1, 5'd4);
        iss_valid = 1'b1; iss_addr = 5'd4;
        step();
        #1;
        chk("first_issue_no_err", {31'd0, iss_err}, 32'd0);
        step();
        iss_valid = 1'b0;
        #1;
        chk("double_issue_err", {31'd0, iss_err}, 32'd1);
        chk("double_issue_busy", {31'd0, rbusy[1]}, 32'd1);
        step();
        chk("err_one_cycle", {31'd0, iss_err}, 32'd0);
        chk("busy_r4_held", {31'd0, rbusy[1]}, 32'd1);
        idle();

        // 6. Clear sweep wipes data and busy bits, ignores traffic.
        wr(0, 5'd9, 32'h55);
        step();
        idle();
        rd(0, 5'd9);
        #1;
        chk("pre_clr_r9", rdata[31:0], 32'h55);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wr(1, 5'd9, 32'h77);
        iss_valid = 1'b1; iss_addr = 5'd10;
        #1;
        chk("clr_ready_low", {31'd0, ready}, 32'd0);
        chk("init_rdata", rdata[31:0], 32'd0);
        chk("init_rbusy", {29'd0, rbusy}, 32'd0);
        sweep_check("sweep3");
        idle();
        rd(0, 5'd9); rd(1, 5'd4); rd(2, 5'd10);
        #1;
        chk("post_clr_r9", rdata[31:0], 32'd0);
        chk("post_clr_rbusy", {29'd0, rbusy}, 32'd0);
        chk("post_clr_iss_err", {31'd0, iss_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
